// File: rtl/full_subtractor_using_half_subtractor_if.sv
// Operand/result bundle for the registered full subtractor.
// The master drives operands; the slave returns a registered result.
interface full_subtractor_using_half_subtractor_if #(
    parameter int WIDTH = 1
);
    logic             in_valid;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic             Bin;
    logic             out_valid;
    logic [WIDTH-1:0] D;
    logic             Bout;
    logic             ovf;

    modport master (
        output in_valid, A, B, Bin,
        input  out_valid, D, Bout, ovf
    );

    modport slave (
        input  in_valid, A, B, Bin,
        output out_valid, D, Bout, ovf
    );
endinterface

// File: rtl/full_subtractor_using_half_subtractor.sv
// Registered ripple-borrow subtractor D = A - B - Bin.
// Each bit cell is two half subtractors with an OR on the borrows.
module half_subtractor (
    input  logic i_x,
    input  logic i_y,
    output logic o_d,
    output logic o_b
);
    assign o_d = i_x ^ i_y;
    assign o_b = ~i_x & i_y;
endmodule

module full_subtractor_using_half_subtractor #(
    parameter int WIDTH = 1
) (
    input logic clk,
    input logic rst,
    full_subtractor_using_half_subtractor_if.slave bus
);
    logic [WIDTH:0]   w_borrow;
    logic [WIDTH-1:0] w_d1;
    logic [WIDTH-1:0] w_b1;
    logic [WIDTH-1:0] w_b2;
    logic [WIDTH-1:0] w_diff;
    logic             w_ovf;

    logic             r_valid;
    logic [WIDTH-1:0] r_d;
    logic             r_bout;
    logic             r_ovf;

    assign w_borrow[0] = bus.Bin;

    for (genvar i = 0; i < WIDTH; i++) begin : g_cell
        half_subtractor u_hs1 (
            .i_x (bus.A[i]),
            .i_y (bus.B[i]),
            .o_d (w_d1[i]),
            .o_b (w_b1[i])
        );
        half_subtractor u_hs2 (
            .i_x (w_d1[i]),
            .i_y (w_borrow[i]),
            .o_d (w_diff[i]),
            .o_b (w_b2[i])
        );
        assign w_borrow[i+1] = w_b1[i] | w_b2[i];
    end

    // Signed overflow: borrow into the sign cell differs from borrow out.
    assign w_ovf = w_borrow[WIDTH] ^ w_borrow[WIDTH-1];

    // Capture a result only on valid; otherwise hold and drop out_valid.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_valid <= 1'b0;
            r_d     <= '0;
            r_bout  <= 1'b0;
            r_ovf   <= 1'b0;
        end else begin
            r_valid <= bus.in_valid;
            if (bus.in_valid) begin
                r_d    <= w_diff;
                r_bout <= w_borrow[WIDTH];
                r_ovf  <= w_ovf;
            end
        end
    end

    assign bus.out_valid = r_valid;
    assign bus.D         = r_d;
    assign bus.Bout      = r_bout;
    assign bus.ovf       = r_ovf;
endmodule

// File: tb/tb_full_subtractor_using_half_subtractor.sv
// Directed and reference-model bench for the registered subtractor.
// Four widths are instantiated and exercised one after another.
module tb_full_subtractor_using_half_subtractor;
    logic clk = 1'b0;
    logic rst;
    int   n_chk = 0;
    int   n_err = 0;

    always #5 clk = ~clk;

    full_subtractor_using_half_subtractor_if #(.WIDTH(1))  fs1 ();
    full_subtractor_using_half_subtractor_if #(.WIDTH(8))  fs8 ();
    full_subtractor_using_half_subtractor_if #(.WIDTH(4))  fs4 ();
    full_subtractor_using_half_subtractor_if #(.WIDTH(16)) fs16 ();

    full_subtractor_using_half_subtractor #(.WIDTH(1)) u_w1 (
        .clk (clk), .rst (rst), .bus (fs1)
    );
    full_subtractor_using_half_subtractor #(.WIDTH(8)) u_w8 (
        .clk (clk), .rst (rst), .bus (fs8)
    );
    full_subtractor_using_half_subtractor #(.WIDTH(4)) u_w4 (
        .clk (clk), .rst (rst), .bus (fs4)
    );
    full_subtractor_using_half_subtractor #(.WIDTH(16)) u_w16 (
        .clk (clk), .rst (rst), .bus (fs16)
    );

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got %0h exp %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // (D,Bout) per (A,B,Bin) = 000..111
    logic [1:0] exp1 [8] = '{2'b00, 2'b11, 2'b11, 2'b01,
                             2'b10, 2'b00, 2'b00, 2'b11};

    // A, B, Bin, D, Bout, ovf
    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic       bin;
        logic [7:0] d;
        logic       bout;
        logic       ovf;
    } vec8_t;

    vec8_t v8 [4] = '{
        '{8'h00, 8'h00, 1'b1, 8'hFF, 1'b1, 1'b0},
        '{8'h80, 8'h01, 1'b0, 8'h7F, 1'b0, 1'b1},
        '{8'h7F, 8'hFF, 1'b0, 8'h80, 1'b1, 1'b1},
        '{8'h55, 8'h55, 1'b0, 8'h00, 1'b0, 1'b0}
    };

    initial begin
        logic [2:0]  abc;
        logic [15:0] ra;
        logic [15:0] rb;
        logic        rbin;
        logic [16:0] udiff;
        int          sdiff;
        int          sa;
        int          sb;

        rst = 1'b1;
        fs1.in_valid = 0;  fs1.A = '0;  fs1.B = '0;  fs1.Bin = 0;
        fs8.in_valid = 0;  fs8.A = '0;  fs8.B = '0;  fs8.Bin = 0;
        fs4.in_valid = 0;  fs4.A = '0;  fs4.B = '0;  fs4.Bin = 0;
        fs16.in_valid = 0; fs16.A = '0; fs16.B = '0; fs16.Bin = 0;
        tick();
        tick();
        chk("rst_w8_valid", 64'(fs8.out_valid), 64'd0);
        chk("rst_w8_d", 64'(fs8.D), 64'd0);
        chk("rst_w8_bout", 64'(fs8.Bout), 64'd0);
        chk("rst_w8_ovf", 64'(fs8.ovf), 64'd0);
        rst = 1'b0;
        tick();

        // WIDTH=1 exhaustive, back to back
        for (int i = 0; i < 8; i++) begin
            abc = 3'(i);
            fs1.A = abc[2];
            fs1.B = abc[1];
            fs1.Bin = abc[0];
            fs1.in_valid = 1'b1;
            tick();
            chk($sformatf("w1_d_%0d", i), 64'(fs1.D), 64'(exp1[i][1]));
            chk($sformatf("w1_bout_%0d", i), 64'(fs1.Bout),
                64'(exp1[i][0]));
            chk($sformatf("w1_ovf_%0d", i), 64'(fs1.ovf),
                64'(exp1[i][0] ^ abc[0]));
            chk($sformatf("w1_valid_%0d", i), 64'(fs1.out_valid), 64'd1);
        end
        fs1.in_valid = 1'b0;

        // WIDTH=8 directed corners
        for (int i = 0; i < 4; i++) begin
            fs8.A = v8[i].a;
            fs8.B = v8[i].b;
            fs8.Bin = v8[i].bin;
            fs8.in_valid = 1'b1;
            tick();
            chk($sformatf("w8_d_%0d", i), 64'(fs8.D), 64'(v8[i].d));
            chk($sformatf("w8_bout_%0d", i), 64'(fs8.Bout),
                64'(v8[i].bout));
            chk($sformatf("w8_ovf_%0d", i), 64'(fs8.ovf), 64'(v8[i].ovf));
            chk($sformatf("w8_valid_%0d", i), 64'(fs8.out_valid), 64'd1);
        end
        fs8.in_valid = 1'b0;

        // WIDTH=4 hold
        fs4.A = 4'd5;
        fs4.B = 4'd3;
        fs4.Bin = 1'b0;
        fs4.in_valid = 1'b1;
        tick();
        chk("hold_d0", 64'(fs4.D), 64'd2);
        chk("hold_v0", 64'(fs4.out_valid), 64'd1);
        fs4.in_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            fs4.A = 4'($urandom);
            fs4.B = 4'($urandom);
            fs4.Bin = 1'($urandom);
            tick();
            chk($sformatf("hold_d_%0d", i), 64'(fs4.D), 64'd2);
            chk($sformatf("hold_bout_%0d", i), 64'(fs4.Bout), 64'd0);
            chk($sformatf("hold_v_%0d", i), 64'(fs4.out_valid), 64'd0);
        end

        // WIDTH=4 reset beats valid
        rst = 1'b1;
        fs4.A = 4'd1;
        fs4.B = 4'd0;
        fs4.Bin = 1'b0;
        fs4.in_valid = 1'b1;
        tick();
        chk("rstpri_d", 64'(fs4.D), 64'd0);
        chk("rstpri_bout", 64'(fs4.Bout), 64'd0);
        chk("rstpri_v", 64'(fs4.out_valid), 64'd0);
        rst = 1'b0;
        tick();
        chk("postrst_d", 64'(fs4.D), 64'd1);
        chk("postrst_v", 64'(fs4.out_valid), 64'd1);
        fs4.in_valid = 1'b0;

        // WIDTH=16 random against arithmetic model
        for (int i = 0; i < 10000; i++) begin
            ra = 16'($urandom);
            rb = 16'($urandom);
            rbin = 1'($urandom);
            if (i == 0) begin ra = 16'h0000; rb = 16'hFFFF; rbin = 1; end
            if (i == 1) begin ra = 16'h8000; rb = 16'h0000; rbin = 1; end
            fs16.A = ra;
            fs16.B = rb;
            fs16.Bin = rbin;
            fs16.in_valid = 1'b1;
            udiff = {1'b0, ra} - {1'b0, rb} - 17'(rbin);
            sa = $signed(ra);
            sb = $signed(rb);
            sdiff = sa - sb - int'(rbin);
            tick();
            chk("rnd_d", 64'(fs16.D), 64'(udiff[15:0]));
            chk("rnd_bout", 64'(fs16.Bout), 64'(ra < 17'(rb) + 17'(rbin)));
            chk("rnd_ovf", 64'(fs16.ovf),
                64'(sdiff > 32767 || sdiff < -32768));
        end
        fs16.in_valid = 1'b0;
        tick();
        chk("rnd_idle_v", 64'(fs16.out_valid), 64'd0);

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end
endmodule
